// File: rtl/gs_pkg.sv
// Shared graphics-system types and widths.
package gs_pkg;

  localparam int unsigned FB_ADDR_W = 24;
  localparam int unsigned FB_DIM_W  = 10;
  localparam int unsigned COLOR_W   = 16;

  // Command type codes understood by the graphics command decoder
  typedef enum logic [2:0] {
    CMD_SET_FB_ADDR   = 3'd0,
    CMD_SELECT_FB     = 3'd1,
    CMD_LINE          = 3'd2,
    CMD_FILL          = 3'd3,
    CMD_CREATE_SPRITE = 3'd4,
    CMD_BITBLT        = 3'd5
  } gs_cmd_e;

  // Active framebuffer geometry
  typedef struct packed {
    logic [FB_ADDR_W-1:0] base;
    logic [FB_DIM_W-1:0]  width;
    logic [FB_DIM_W-1:0]  height;
  } fb_cfg_t;

endpackage

// File: rtl/gs_pix_fifo.sv
// Small synchronous write queue between the address stage and the memory port.
module gs_pix_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop from a full queue frees the slot being written in the same cycle
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/gs_fb_writer.sv
// Framebuffer pixel sink: clips incoming pixels, forms linear addresses and
// queues writes toward the memory manager.
module gs_fb_writer #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned COORD_W    = 16,
  parameter int unsigned COLOR_W    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cfg_we,
  input  logic [ADDR_W-1:0]  i_cfg_base,
  input  logic [9:0]         i_cfg_width,
  input  logic [9:0]         i_cfg_height,
  output logic               o_cfg_rej,
  input  logic               i_px_valid,
  output logic               o_px_ready,
  input  logic [COORD_W-1:0] i_px_x,
  input  logic [COORD_W-1:0] i_px_y,
  input  logic [COLOR_W-1:0] i_px_color,
  output logic               o_mem_wr,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [COLOR_W-1:0] o_mem_data,
  input  logic               i_mem_ack,
  output logic [15:0]        o_clip_cnt,
  output logic               o_idle
);

  import gs_pkg::*;

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PROD_W = 2 * FB_DIM_W;
  localparam int unsigned ENT_W  = ADDR_W + COLOR_W;

  fb_cfg_t              r_cfg;
  logic                 r_cfg_rej;
  logic                 r_s1_valid;
  logic                 r_s1_clip;
  logic [PROD_W-1:0]    r_s1_prod;
  logic [FB_DIM_W-1:0]  r_s1_x;
  logic [COLOR_W-1:0]   r_s1_color;
  logic [15:0]          r_clip_cnt;

  logic                 w_accept;
  logic                 w_clip;
  logic                 w_x_neg;
  logic                 w_y_neg;
  logic [ADDR_W-1:0]    w_addr;
  logic                 w_push;
  logic                 w_pop;
  logic [ENT_W-1:0]     w_head;
  logic [CNT_W-1:0]     w_count;
  logic [CNT_W:0]       w_fill;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_idle;

  // Signed clip: negatives are caught by the sign bit, so the upper-bound
  // tests can be unsigned against zero-extended geometry.
  assign w_x_neg = i_px_x[COORD_W-1];
  assign w_y_neg = i_px_y[COORD_W-1];
  assign w_clip  = w_x_neg | w_y_neg
                 | (i_px_x >= COORD_W'(r_cfg.width))
                 | (i_px_y >= COORD_W'(r_cfg.height));

  assign w_fill     = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_s1_valid);
  assign o_px_ready = ~rst & ~w_full & (w_fill < (CNT_W+1)'(FIFO_DEPTH));
  assign w_accept   = i_px_valid & o_px_ready;

  assign w_idle = ~r_s1_valid & w_empty;
  assign o_idle = w_idle;

  assign w_addr = ADDR_W'(r_cfg.base) + ADDR_W'(r_s1_prod) + ADDR_W'(r_s1_x);
  assign w_push = r_s1_valid & ~r_s1_clip;
  assign w_pop  = o_mem_wr & i_mem_ack;

  assign o_mem_wr   = ~w_empty;
  assign o_mem_addr = w_head[ENT_W-1:COLOR_W];
  assign o_mem_data = w_head[COLOR_W-1:0];
  assign o_cfg_rej  = r_cfg_rej;
  assign o_clip_cnt = r_clip_cnt;

  // Geometry load, only while nothing is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg     <= '0;
      r_cfg_rej <= 1'b0;
    end else begin
      r_cfg_rej <= 1'b0;
      if (i_cfg_we) begin
        if (w_idle && !w_accept) begin
          r_cfg <= '{base:   FB_ADDR_W'(i_cfg_base),
                     width:  i_cfg_width,
                     height: i_cfg_height};
        end else begin
          r_cfg_rej <= 1'b1;
        end
      end
    end
  end

  // Stage-1 valid flag
  always_ff @(posedge clk) begin
    if (rst) r_s1_valid <= 1'b0;
    else     r_s1_valid <= w_accept;
  end

  // Stage-1 payload: clip decision, row offset, column and colour
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_clip  <= w_clip;
      r_s1_prod  <= PROD_W'(i_px_y[FB_DIM_W-1:0]) * PROD_W'(r_cfg.width);
      r_s1_x     <= i_px_x[FB_DIM_W-1:0];
      r_s1_color <= i_px_color;
    end
  end

  // Saturating count of clipped pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clip_cnt <= '0;
    end else if (r_s1_valid && r_s1_clip && (r_clip_cnt != '1)) begin
      r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end

  gs_pix_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_addr, r_s1_color}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_gs_fb_writer.sv
// Scoreboard bench for gs_fb_writer with a transaction-level reference model.
module tb_gs_fb_writer;

  typedef struct {
    logic [23:0] a;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [23:0] cfg_base = '0;
  logic [9:0]  cfg_w = '0;
  logic [9:0]  cfg_h = '0;
  logic        px_valid = 1'b0;
  logic [15:0] px_x = '0;
  logic [15:0] px_y = '0;
  logic [15:0] px_c = '0;
  logic        mem_ack = 1'b0;
  logic        o_cfg_rej, o_px_ready, o_mem_wr, o_idle;
  logic [23:0] o_mem_addr;
  logic [15:0] o_mem_data, o_clip_cnt;

  int   ack_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int   compared = 0;
  int   mism = 0;
  bit   hs_next = 0;

  // reference model state
  int   m_base = 0, m_w = 0, m_h = 0, m_clip = 0;
  bit   m_rej = 0;
  bit   pend_v = 0, pend_clip = 0;
  exp_t pend_e;
  exp_t exp_q[$];

  gs_fb_writer #(.ADDR_W(24), .COORD_W(16), .COLOR_W(16), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cfg_we     (cfg_we),
    .i_cfg_base   (cfg_base),
    .i_cfg_width  (cfg_w),
    .i_cfg_height (cfg_h),
    .o_cfg_rej    (o_cfg_rej),
    .i_px_valid   (px_valid),
    .o_px_ready   (o_px_ready),
    .i_px_x       (px_x),
    .i_px_y       (px_y),
    .i_px_color   (px_c),
    .o_mem_wr     (o_mem_wr),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .i_mem_ack    (mem_ack),
    .o_clip_cnt   (o_clip_cnt),
    .o_idle       (o_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    mem_ack = (ack_mode == 2) ? ($urandom_range(0, 2) != 0) : (ack_mode != 0);
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: checks this cycle's outputs, then advances the model across the coming edge
  always @(negedge clk) begin
    int outst;
    int x, y;
    longint ad;
    outst = exp_q.size() + int'(pend_v);
    chk("px_ready", o_px_ready, (!rst && outst < 4));
    chk("idle", o_idle, (outst == 0));
    chk("mem_wr", o_mem_wr, (exp_q.size() != 0));
    chk("clip_cnt", o_clip_cnt, m_clip);
    chk("cfg_rej", o_cfg_rej, m_rej);
    if (o_mem_wr === 1'b1 && mem_ack && exp_q.size() > 0) begin
      chk("mem_addr", o_mem_addr, exp_q[0].a);
      chk("mem_data", o_mem_data, exp_q[0].d);
      void'(exp_q.pop_front());
    end
    hs_next = px_valid && (o_px_ready === 1'b1);
    if (rst) begin
      m_base = 0; m_w = 0; m_h = 0; m_clip = 0; m_rej = 0;
      pend_v = 0;
      exp_q.delete();
    end else begin
      m_rej = 0;
      if (cfg_we) begin
        if (outst == 0 && !hs_next) begin
          m_base = int'(cfg_base); m_w = int'(cfg_w); m_h = int'(cfg_h);
        end else begin
          m_rej = 1;
        end
      end
      if (pend_v) begin
        if (pend_clip) m_clip = (m_clip < 65535) ? m_clip + 1 : 65535;
        else exp_q.push_back(pend_e);
        pend_v = 0;
      end
      if (hs_next) begin
        x = int'($signed(px_x));
        y = int'($signed(px_y));
        pend_clip = (x < 0) || (y < 0) || (x >= m_w) || (y >= m_h);
        if (!pend_clip) begin
          ad = (longint'(m_base) + longint'(y) * m_w + x) % (64'd1 << 24);
          pend_e.a = 24'(ad);
          pend_e.d = px_c;
        end
        pend_v = 1;
      end
    end
  end

  task automatic do_cfg(input int base, input int w, input int h);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_base = 24'(base); cfg_w = 10'(w); cfg_h = 10'(h);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic send_px(input int x, input int y, input int c);
    int n;
    n = 0;
    px_valid = 1'b1; px_x = 16'(x); px_y = 16'(y); px_c = 16'(c);
    @(negedge clk);
    while (o_px_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++; mism++;
      $display("FAIL px_handshake: got no ready expected ready within 200 cycles");
    end
    @(posedge clk); #1;
    px_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (o_idle !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      compared++; mism++;
      $display("FAIL wait_idle: got busy expected idle within 300 cycles");
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, h, x, y;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single write
    ack_mode = 1;
    do_cfg(24'h001000, 320, 240);
    send_px(10, 2, 16'hF800);
    wait_idle();

    // 2: clip boundaries
    send_px(-1, 5, 16'h0001);
    send_px(320, 0, 16'h0002);
    send_px(0, 240, 16'h0003);
    send_px(319, 239, 16'h07E0);
    wait_idle();

    // 3: backpressure with 8 pixels, release ack later
    ack_mode = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_px(i * 3, i, 16'h1000 + i);
      end
      begin
        cycles(30);
        ack_mode = 1;
      end
    join
    wait_idle();

    // 4: config rejected while busy, accepted when idle
    ack_mode = 0;
    send_px(5, 5, 16'hAAAA);
    cycles(2);
    do_cfg(24'h222222, 16, 16);
    ack_mode = 1;
    wait_idle();
    send_px(7, 1, 16'hBBBB);
    wait_idle();
    do_cfg(24'h000400, 64, 64);
    send_px(63, 63, 16'hCCCC);
    wait_idle();

    // 5: address wrap
    do_cfg(24'hFFFFF0, 32, 32);
    send_px(31, 0, 16'h1234);
    wait_idle();

    // 6: reset with queued writes
    do_cfg(0, 320, 240);
    ack_mode = 0;
    for (int i = 0; i < 3; i++) send_px(i, i, 16'h5500 + i);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    ack_mode = 1;
    for (int i = 0; i < 3; i++) send_px(i, i, 16'h6600 + i);
    wait_idle();

    // random phase
    do_cfg(24'h000100, 100, 50);
    w = 100; h = 50;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (k % 250 == 0) ack_mode = ($urandom_range(0, 4) == 0) ? 0 : (($urandom_range(0, 3) == 0) ? 1 : 2);
      rst = ($urandom_range(0, 599) == 0);
      if (!px_valid || hs_next) begin
        px_valid = ($urandom_range(0, 3) != 0);
        x = $urandom_range(0, w + 3) - 2;
        y = $urandom_range(0, h + 3) - 2;
        if ($urandom_range(0, 31) == 0) x = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        if ($urandom_range(0, 31) == 0) y = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        px_x = 16'(x); px_y = 16'(y); px_c = 16'($urandom);
      end
      cfg_we = ($urandom_range(0, 19) == 0);
      if (cfg_we) begin
        case ($urandom_range(0, 4))
          0: w = 0;
          1: w = 1;
          2: w = 1023;
          default: w = $urandom_range(1, 1023);
        endcase
        h = ($urandom_range(0, 3) == 0) ? 1023 : $urandom_range(1, 600);
        cfg_base = 24'($urandom); cfg_w = 10'(w); cfg_h = 10'(h);
      end
    end
    @(posedge clk); #1;
    px_valid = 1'b0; cfg_we = 1'b0; rst = 1'b0; ack_mode = 1;
    wait_idle();
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
